// File: rtl/latch_sr_if.sv
// Bundle of per-cell set/reset requests and registered state outputs for latch_sr.
interface latch_sr_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qn;
   logic [WIDTH-1:0] conflict;

   // Request decode side drives S/R and observes the stored state.
   modport master (
      output S,
      output R,
      input  Q,
      input  Qn,
      input  conflict
   );

   // Storage side samples S/R and presents the registered state.
   modport slave (
      input  S,
      input  R,
      output Q,
      output Qn,
      output conflict
   );
endinterface

// File: rtl/latch_sr.sv
// Clocked set/reset storage for the magnetron control path.
// WIDTH independent cells; each resolves S/R on the rising edge of clk.
// The S=R=1 case is resolved deterministically by RESET_DOMINANT and flagged
// on conflict for one cycle. Qn is taken from the Q register, so it can
// never glitch or agree with Q.
module latch_sr #(
   parameter int WIDTH          = 1,
   parameter bit RESET_DOMINANT = 1'b1
) (
   input logic       clk,
   input logic       rst_n,
   latch_sr_if.slave bus
);

   logic [WIDTH-1:0] Q_q;
   logic [WIDTH-1:0] Q_d;
   logic [WIDTH-1:0] conflict_q;
   logic [WIDTH-1:0] conflict_d;

   // Next state per cell: request priority chosen at elaboration time.
   always_comb begin
      Q_d        = Q_q;
      conflict_d = bus.S & bus.R;
      if (RESET_DOMINANT) begin
         Q_d = (Q_q | bus.S) & ~bus.R;
      end else begin
         Q_d = (Q_q & ~bus.R) | bus.S;
      end
   end

   // State register with synchronous active-low clear of every cell.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Q_q        <= '0;
         conflict_q <= '0;
      end else begin
         Q_q        <= Q_d;
         conflict_q <= conflict_d;
      end
   end

   assign bus.Q        = Q_q;
   assign bus.Qn       = ~Q_q;
   assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_latch_sr.sv
// Directed bench for latch_sr: reset-dominant, set-dominant and 4-wide cells.
module tb_latch_sr;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   latch_sr_if #(.WIDTH(1)) rd_if ();
   latch_sr_if #(.WIDTH(1)) sd_if ();
   latch_sr_if #(.WIDTH(4)) w4_if ();

   latch_sr #(.WIDTH(1), .RESET_DOMINANT(1'b1)) dut_rd (.clk(clk), .rst_n(rst_n), .bus(rd_if.slave));
   latch_sr #(.WIDTH(1), .RESET_DOMINANT(1'b0)) dut_sd (.clk(clk), .rst_n(rst_n), .bus(sd_if.slave));
   latch_sr #(.WIDTH(4), .RESET_DOMINANT(1'b1)) dut_w4 (.clk(clk), .rst_n(rst_n), .bus(w4_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rd_if.S = 1'b1; rd_if.R = 1'b0;
      sd_if.S = 1'b1; sd_if.R = 1'b0;
      w4_if.S = 4'hF; w4_if.R = 4'h0;
      step();
      step();
      checks++;
      if (rd_if.Q !== 1'b0) begin errors++; $display("FAIL reset_Q: got %b expected 0", rd_if.Q); end
      checks++;
      if (rd_if.Qn !== 1'b1) begin errors++; $display("FAIL reset_Qn: got %b expected 1", rd_if.Qn); end
      checks++;
      if (rd_if.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", rd_if.conflict); end
      checks++;
      if (sd_if.Q !== 1'b0) begin errors++; $display("FAIL reset_sd_Q: got %b expected 0", sd_if.Q); end
      checks++;
      if (w4_if.Q !== 4'h0 || w4_if.Qn !== 4'hF) begin
         errors++; $display("FAIL reset_w4: got Q=%b Qn=%b expected Q=0000 Qn=1111", w4_if.Q, w4_if.Qn);
      end
      rst_n = 1'b1;
      rd_if.S = 1'b0; sd_if.S = 1'b0; w4_if.S = 4'h0;
      step();
      checks++;
      if (rd_if.Q !== 1'b0) begin errors++; $display("FAIL release_hold_Q: got %b expected 0", rd_if.Q); end
   endtask

   task automatic test_set_reset_hold();
      rd_if.S = 1'b0; rd_if.R = 1'b1;
      step(); step();
      checks++;
      if (rd_if.Q !== 1'b0) begin errors++; $display("FAIL reset_req_Q: got %b expected 0", rd_if.Q); end
      rd_if.R = 1'b0;
      step(); step();
      checks++;
      if (rd_if.Q !== 1'b0) begin errors++; $display("FAIL hold0_Q: got %b expected 0", rd_if.Q); end
      rd_if.S = 1'b1;
      step();
      checks++;
      if (rd_if.Q !== 1'b1) begin errors++; $display("FAIL set_first_Q: got %b expected 1", rd_if.Q); end
      step();
      checks++;
      if (rd_if.Q !== 1'b1 || rd_if.conflict !== 1'b0) begin
         errors++; $display("FAIL set_idem: got Q=%b conflict=%b expected Q=1 conflict=0", rd_if.Q, rd_if.conflict);
      end
      rd_if.S = 1'b0;
      step(); step();
      checks++;
      if (rd_if.Q !== 1'b1 || rd_if.Qn !== 1'b0) begin
         errors++; $display("FAIL hold1: got Q=%b Qn=%b expected Q=1 Qn=0", rd_if.Q, rd_if.Qn);
      end
   endtask

   task automatic test_conflict_reset_dominant();
      rd_if.S = 1'b1; rd_if.R = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (rd_if.Q !== 1'b0 || rd_if.conflict !== 1'b1) begin
            errors++; $display("FAIL rd_both_%0d: got Q=%b conflict=%b expected Q=0 conflict=1", i, rd_if.Q, rd_if.conflict);
         end
      end
      rd_if.S = 1'b0; rd_if.R = 1'b0;
      step();
      checks++;
      if (rd_if.Q !== 1'b0 || rd_if.conflict !== 1'b0) begin
         errors++; $display("FAIL rd_release: got Q=%b conflict=%b expected Q=0 conflict=0", rd_if.Q, rd_if.conflict);
      end
   endtask

   task automatic test_conflict_set_dominant();
      checks++;
      if (sd_if.Q !== 1'b0) begin errors++; $display("FAIL sd_start_Q: got %b expected 0", sd_if.Q); end
      sd_if.S = 1'b1; sd_if.R = 1'b1;
      step();
      checks++;
      if (sd_if.Q !== 1'b1 || sd_if.conflict !== 1'b1 || sd_if.Qn !== 1'b0) begin
         errors++; $display("FAIL sd_both: got Q=%b Qn=%b conflict=%b expected Q=1 Qn=0 conflict=1", sd_if.Q, sd_if.Qn, sd_if.conflict);
      end
      sd_if.S = 1'b0; sd_if.R = 1'b0;
      step();
      checks++;
      if (sd_if.Q !== 1'b1 || sd_if.conflict !== 1'b0) begin
         errors++; $display("FAIL sd_release: got Q=%b conflict=%b expected Q=1 conflict=0", sd_if.Q, sd_if.conflict);
      end
   endtask

   task automatic test_mid_reset();
      rd_if.S = 1'b1; rd_if.R = 1'b0;
      step();
      checks++;
      if (rd_if.Q !== 1'b1) begin errors++; $display("FAIL mid_pre_Q: got %b expected 1", rd_if.Q); end
      rst_n = 1'b0;
      step();
      checks++;
      if (rd_if.Q !== 1'b0 || rd_if.Qn !== 1'b1) begin
         errors++; $display("FAIL mid_reset: got Q=%b Qn=%b expected Q=0 Qn=1", rd_if.Q, rd_if.Qn);
      end
      checks++;
      if (sd_if.Q !== 1'b0) begin errors++; $display("FAIL mid_reset_sd: got %b expected 0", sd_if.Q); end
      rst_n = 1'b1;
      step();
      checks++;
      if (rd_if.Q !== 1'b1) begin errors++; $display("FAIL mid_after_Q: got %b expected 1", rd_if.Q); end
      rd_if.S = 1'b0;
   endtask

   task automatic test_width4();
      w4_if.S = 4'b0101; w4_if.R = 4'b1010;
      step();
      checks++;
      if (w4_if.Q !== 4'b0101 || w4_if.Qn !== 4'b1010 || w4_if.conflict !== 4'b0000) begin
         errors++; $display("FAIL w4_first: got Q=%b Qn=%b conflict=%b expected Q=0101 Qn=1010 conflict=0000", w4_if.Q, w4_if.Qn, w4_if.conflict);
      end
      w4_if.S = 4'b0010; w4_if.R = 4'b0000;
      step();
      checks++;
      if (w4_if.Q !== 4'b0111 || w4_if.Qn !== 4'b1000) begin
         errors++; $display("FAIL w4_second: got Q=%b Qn=%b expected Q=0111 Qn=1000", w4_if.Q, w4_if.Qn);
      end
      w4_if.S = 4'b1111; w4_if.R = 4'b0011;
      step();
      checks++;
      if (w4_if.Q !== 4'b1100 || w4_if.Qn !== 4'b0011 || w4_if.conflict !== 4'b0011) begin
         errors++; $display("FAIL w4_mixed_conflict: got Q=%b Qn=%b conflict=%b expected Q=1100 Qn=0011 conflict=0011", w4_if.Q, w4_if.Qn, w4_if.conflict);
      end
      w4_if.S = 4'b0000; w4_if.R = 4'b0000;
      step();
      checks++;
      if (w4_if.Q !== 4'b1100 || w4_if.conflict !== 4'b0000) begin
         errors++; $display("FAIL w4_hold: got Q=%b conflict=%b expected Q=1100 conflict=0000", w4_if.Q, w4_if.conflict);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      rd_if.S = 1'b0; rd_if.R = 1'b0;
      sd_if.S = 1'b0; sd_if.R = 1'b0;
      w4_if.S = 4'h0; w4_if.R = 4'h0;
      test_reset();
      test_set_reset_hold();
      test_conflict_reset_dominant();
      test_conflict_set_dominant();
      test_mid_reset();
      test_width4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
